// File: rtl/cache_refill_ctrl.sv
// Load-port sequencer for a cache/memory pair: lookup, block refill on miss; optional CRITICAL_WORD_FIRST_EN.
// Latency: hit responds 3 cycles after acceptance; miss 3 + BLOCK_WORDS*(1+L). One request in flight; cpu_ready only in IDLE.
module cache_refill_ctrl #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_valid,
    output logic [DATA_W-1:0] cpu_data,
    output logic              cpu_hit,
    output logic              cache_lookup,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic              cache_hit,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic              cache_we,
    output logic [DATA_W-1:0] cache_wdata,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              busy
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, CHECK, FILL_REQ, FILL_WAIT, RESP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [OFF_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   cpu_data_q, cpu_data_d;
    logic                cpu_hit_q, cpu_hit_d;
    logic [OFF_W-1:0]    word_off;
    logic [ADDR_W-1:0]   fill_addr;
    logic                last_word;
    logic                crit_word;

    // The OFF_W-bit sum wraps inside the block, so the fill never leaves the aligned block.
`ifdef CRITICAL_WORD_FIRST_EN
    assign word_off = req_addr_q[OFF_W-1:0] + cnt_q;
`else
    assign word_off = cnt_q;
`endif
    assign fill_addr = {req_addr_q[ADDR_W-1:OFF_W], word_off};
    assign last_word = (cnt_q == OFF_W'(BLOCK_WORDS - 1));
    assign crit_word = (word_off == req_addr_q[OFF_W-1:0]);

    assign cpu_data = cpu_data_q;
    assign cpu_hit  = cpu_hit_q;

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        cpu_data_d   = cpu_data_q;
        cpu_hit_d    = cpu_hit_q;
        cpu_ready    = 1'b0;
        cpu_valid    = 1'b0;
        busy         = 1'b1;
        cache_lookup = 1'b0;
        cache_addr   = '0;
        cache_we     = 1'b0;
        cache_wdata  = '0;
        mem_rd       = 1'b0;
        mem_addr     = '0;
        case (state_q)
            IDLE: begin
                cpu_ready = 1'b1;
                busy      = 1'b0;
                if (cpu_req) begin
                    req_addr_d = cpu_addr;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                cache_lookup = 1'b1;
                cache_addr   = req_addr_q;
                state_d      = CHECK;
            end
            CHECK: begin
                if (cache_hit) begin
                    cpu_data_d = cache_rdata;
                    cpu_hit_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = FILL_REQ;
                end
            end
            FILL_REQ: begin
                mem_rd   = 1'b1;
                mem_addr = fill_addr;
                state_d  = FILL_WAIT;
            end
            FILL_WAIT: begin
                mem_addr = fill_addr;
                if (mem_valid) begin
                    cache_we    = 1'b1;
                    cache_addr  = fill_addr;
                    cache_wdata = mem_rdata;
                    if (crit_word) begin
                        data_d = mem_rdata;
                    end
                    // cpu_data only moves on the edge into RESP so it holds between responses.
                    if (last_word) begin
                        cpu_data_d = crit_word ? mem_rdata : data_q;
                        cpu_hit_d  = 1'b0;
                        state_d    = RESP;
                    end else begin
                        cnt_d   = cnt_q + OFF_W'(1);
                        state_d = FILL_REQ;
                    end
                end
            end
            RESP: begin
                cpu_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            cpu_data_q <= '0;
            cpu_hit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            cpu_data_q <= cpu_data_d;
            cpu_hit_q  <= cpu_hit_d;
        end
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: reset, table vectors, abort-on-reset sequence and randomized requests against a block-level model.
module tb_cache_refill_ctrl;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_ready, cpu_valid, cpu_hit;
    logic [DW-1:0] cpu_data;
    logic          cache_lookup, cache_hit, cache_we;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_rdata, cache_wdata;
    logic          mem_rd, mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mem_salt;

    cache_refill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(BW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
        .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_hit(cpu_hit),
        .cache_lookup(cache_lookup), .cache_addr(cache_addr), .cache_hit(cache_hit),
        .cache_rdata(cache_rdata), .cache_we(cache_we), .cache_wdata(cache_wdata),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory contents: every word holds salt + its own address.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return mem_salt + DW'(a);
    endfunction

    // k-th address the refill must read for a miss on word address a.
    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a, input int k);
        int base, off;
        base = int'(a) - (int'(a) % BW);
`ifdef CRITICAL_WORD_FIRST_EN
        off = ((int'(a) % BW) + k) % BW;
`else
        off = k;
`endif
        return AW'(base + off);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {cpu_ready, busy, cpu_valid, cpu_hit, cache_lookup, cache_we, mem_rd}, 64'b1000000);
        chk({tag, "_data"}, {cpu_data, cache_wdata}, 64'd0);
        chk({tag, "_addr"}, {cache_addr, mem_addr}, 64'd0);
    endtask

    // Plays cache and memory for one request; abort_at>0 asserts rst alongside that memory response.
    task automatic run_req(input logic [AW-1:0] addr, input bit hit, input logic [DW-1:0] rdata,
                           input int lat, input int abort_at,
                           output int v_cyc, output logic [DW-1:0] v_data, output bit v_hit,
                           output logic [AW-1:0] first_maddr);
        int exp_v, limit, nrd, nresp, nvalid, abort_cyc, pend_cyc;
        bit pend, look_prev, genuine;
        bit bad_rb, bad_ovl, bad_look, bad_rd, bad_we, bad_post;
        logic [AW-1:0] pend_addr;
        exp_v = hit ? 3 : 3 + BW * (1 + lat);
        limit = (abort_at > 0) ? 200 : exp_v + 2;
        nrd = 0; nresp = 0; nvalid = 0; abort_cyc = -1; pend_cyc = 0;
        pend = 0; look_prev = 0;
        bad_rb = 0; bad_ovl = 0; bad_look = 0; bad_rd = 0; bad_we = 0; bad_post = 0;
        pend_addr = '0; v_cyc = -1; v_data = '0; v_hit = 0; first_maddr = '0;
        for (int c = 0; c <= limit; c++) begin
            @(negedge clk);
            rst = 1'b0;
            genuine = 0;
            if (c == 0) begin
                cpu_req = 1'b1; cpu_addr = addr;
            end else if (abort_cyc < 0 && c < exp_v) begin
                cpu_req = 1'($urandom_range(0, 1)); cpu_addr = AW'($urandom);
            end else begin
                cpu_req = 1'b0;
            end
            cache_hit   = look_prev ? hit : 1'($urandom_range(0, 1));
            cache_rdata = look_prev ? rdata : $urandom;
            mem_valid   = 1'b0;
            mem_rdata   = $urandom;
            if (pend && c == pend_cyc + lat) begin
                mem_valid = 1'b1; mem_rdata = mem_word(pend_addr);
                pend = 0; genuine = 1; nresp++;
                if (nresp == abort_at) begin
                    rst = 1'b1; abort_cyc = c; limit = c + 10;
                end
            end else if (!pend && $urandom_range(0, 5) == 0) begin
                mem_valid = 1'b1;
            end
            #1;
            if (c == 0) chk("accept_rdy", cpu_ready, 1);
            if (busy === cpu_ready) bad_rb = 1;
            if (int'(cache_lookup) + int'(cache_we) + int'(mem_rd) > 1) bad_ovl = 1;
            if (cache_lookup !== 1'(c == 1) || (c == 1 && cache_addr !== addr)) bad_look = 1;
            if (mem_rd === 1'b1) begin
                if (abort_cyc >= 0 && c > abort_cyc) bad_post = 1;
                else if (hit || nrd >= BW || c != 3 + nrd * (1 + lat) || mem_addr !== exp_addr(addr, nrd))
                    bad_rd = 1;
                if (nrd == 0) first_maddr = mem_addr;
                nrd++; pend = 1; pend_cyc = c; pend_addr = mem_addr;
            end
            if (abort_cyc >= 0 && c == abort_cyc) begin
                // the write landing in the reset cycle itself is left unconstrained
            end else if (abort_cyc >= 0 && c > abort_cyc) begin
                if (cache_we !== 1'b0) bad_post = 1;
            end else if (cache_we !== genuine ||
                         (genuine && (cache_addr !== pend_addr || cache_wdata !== mem_rdata))) begin
                bad_we = 1;
            end
            if (cpu_valid === 1'b1) begin
                nvalid++;
                if (abort_cyc >= 0) bad_post = 1;
                else if (v_cyc < 0) begin
                    v_cyc = c; v_data = cpu_data; v_hit = cpu_hit;
                end
            end
            if (abort_cyc >= 0 && c == abort_cyc + 1) check_reset_outputs("abort_next");
            if (abort_cyc < 0 && c == exp_v + 1) begin
                chk("data_hold", cpu_data, v_data);
                chk("ready_after", cpu_ready, 1);
            end
            look_prev = cache_lookup;
        end
        chk("ready_busy", bad_rb, 0);
        chk("strobe_excl", bad_ovl, 0);
        chk("lookup", bad_look, 0);
        chk("mem_rd_seq", bad_rd, 0);
        chk("cache_we", bad_we, 0);
        if (abort_cyc >= 0) begin
            chk("post_abort", bad_post, 0);
            chk("rd_before_abort", nrd, abort_at);
        end else begin
            chk("rd_count", nrd, hit ? 0 : BW);
            chk("valid_count", nvalid, 1);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        bit            hit;
        logic [DW-1:0] rdata;
        int            lat;
        logic [DW-1:0] exp_data;
        bit            exp_hit;
        int            exp_lat;
        logic [AW-1:0] exp_first;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int            v_cyc;
        logic [DW-1:0] v_data;
        bit            v_hit;
        logic [AW-1:0] fm;

        vecs[0] = '{15'h0123, 1, 32'hDEADBEEF, 2, 32'hDEADBEEF, 1, 3, 15'h0000};
`ifdef CRITICAL_WORD_FIRST_EN
        vecs[1] = '{15'h0126, 0, 32'h0, 2, 32'h00001126, 0, 15, 15'h0126};
        vecs[2] = '{15'h7FFF, 0, 32'h0, 1, 32'h00008FFF, 0, 11, 15'h7FFF};
        vecs[5] = '{15'h0AB1, 0, 32'h0, 4, 32'h00001AB1, 0, 23, 15'h0AB1};
`else
        vecs[1] = '{15'h0126, 0, 32'h0, 2, 32'h00001126, 0, 15, 15'h0124};
        vecs[2] = '{15'h7FFF, 0, 32'h0, 1, 32'h00008FFF, 0, 11, 15'h7FFC};
        vecs[5] = '{15'h0AB1, 0, 32'h0, 4, 32'h00001AB1, 0, 23, 15'h0AB0};
`endif
        vecs[3] = '{15'h0000, 0, 32'h0, 3, 32'h00001000, 0, 19, 15'h0000};
        vecs[4] = '{15'h5A53, 1, 32'h0BADF00D, 1, 32'h0BADF00D, 1, 3, 15'h0000};

        mem_salt    = 32'h1000;
        rst         = 1'b1;
        cpu_req     = 1'b1;
        cpu_addr    = 15'h0123;
        cache_hit   = 1'b1;
        cache_rdata = '0;
        mem_valid   = 1'b0;
        mem_rdata   = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("in_reset");
        @(negedge clk);
        rst = 1'b0; cpu_req = 1'b0;
        #1;
        check_reset_outputs("released");
        @(negedge clk);
        #1;
        check_reset_outputs("no_accept");

        for (int i = 0; i < 6; i++) begin
            run_req(vecs[i].addr, vecs[i].hit, vecs[i].rdata, vecs[i].lat, 0, v_cyc, v_data, v_hit, fm);
            chk($sformatf("vec%0d_lat", i), v_cyc, vecs[i].exp_lat);
            chk($sformatf("vec%0d_data", i), v_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_hit", i), v_hit, vecs[i].exp_hit);
            chk($sformatf("vec%0d_first", i), fm, vecs[i].exp_first);
        end

        run_req(15'h0040, 0, 32'h0, 2, 2, v_cyc, v_data, v_hit, fm);
        chk("abort_no_valid", v_cyc, -1);
        run_req(15'h0041, 1, 32'h600DCAFE, 1, 0, v_cyc, v_data, v_hit, fm);
        chk("after_abort_lat", v_cyc, 3);
        chk("after_abort_data", v_data, 32'h600DCAFE);
        chk("after_abort_hit", v_hit, 1);

        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] rd;
            bit            h;
            int            l;
            mem_salt = $urandom;
            a  = AW'($urandom);
            rd = $urandom;
            h  = 1'($urandom_range(0, 1));
            l  = $urandom_range(1, 4);
            run_req(a, h, rd, l, 0, v_cyc, v_data, v_hit, fm);
            chk("rnd_lat", v_cyc, h ? 3 : 3 + BW * (1 + l));
            chk("rnd_data", v_data, h ? rd : mem_word(a));
            chk("rnd_hit", v_hit, h);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
